// File: rtl/ps2_pkg.sv
// Shared PS/2 constants used by the scan-code receiver and the scan-code buffer.
package ps2_pkg;

  localparam int SCAN_W     = 8;
  localparam logic [SCAN_W-1:0] PS2_BREAK = 8'hF0;
  localparam logic [SCAN_W-1:0] PS2_EXT   = 8'hE0;
  localparam int FIFO_DEPTH = 16;

  // Occupancy counter width: must hold the value DEPTH itself, not just DEPTH-1.
  function automatic int count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ps2_code_fifo_if.sv
// Bus between the scan-code producer/consumer (master) and the buffer (slave).
// Handshake: push writes din on any edge where it is high; pop consumes dout on any
// edge where it is high; dout is meaningful only while empty is low (it reads 0 otherwise).
interface ps2_code_fifo_if
  import ps2_pkg::*;
#(
  parameter int WIDTH = SCAN_W,
  parameter int DEPTH = FIFO_DEPTH
);
  localparam int CW = count_w(DEPTH);

  logic [WIDTH-1:0] din;
  logic             push;
  logic             pop;
  logic             clear;
  logic [WIDTH-1:0] dout;
  logic             empty;
  logic             full;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output din, push, pop, clear,
    input  dout, empty, full, count, overflow, underflow
  );

  modport slave (
    input  din, push, pop, clear,
    output dout, empty, full, count, overflow, underflow
  );

endinterface

// File: rtl/ps2_fifo_mem.sv
// Scan-code storage array: one synchronous write port, one asynchronous read port, no reset.
module ps2_fifo_mem
  import ps2_pkg::*;
#(
  parameter int WIDTH = SCAN_W,
  parameter int DEPTH = FIFO_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ps2_code_fifo.sv
// Multi-entry PS/2 scan-code buffer with occupancy status, drop/overwrite full policy,
// sticky overflow/underflow flags and synchronous flush.
module ps2_code_fifo
  import ps2_pkg::*;
#(
  parameter int WIDTH     = SCAN_W,
  parameter int DEPTH     = FIFO_DEPTH,
  parameter int OVERWRITE = 0
) (
  input  logic           clk,
  input  logic           reset,
  ps2_code_fifo_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_w(DEPTH);
  localparam logic OVW = (OVERWRITE != 0);

  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_empty;
  logic             w_full;
  logic             w_wr;
  logic             w_rd;
  logic             w_we;
  logic [WIDTH-1:0] w_rd_data;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));

  // A write goes through unless full with nothing leaving; in overwrite mode the
  // oldest entry is retired by advancing the read pointer alongside the write.
  assign w_wr = bus.push && (!w_full || bus.pop || OVW);
  assign w_rd = (bus.pop && !w_empty) || (bus.push && !bus.pop && w_full && OVW);
  assign w_we = w_wr && reset && !bus.clear;

  ps2_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.din),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (!reset || bus.clear) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (bus.push && !bus.pop && w_full) r_overflow  <= 1'b1;
      if (bus.pop && w_empty)             r_underflow <= 1'b1;
    end
  end

  assign bus.dout      = w_empty ? '0 : w_rd_data;
  assign bus.empty     = w_empty;
  assign bus.full      = w_full;
  assign bus.count     = r_count;
  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;

endmodule

// File: tb/tb_ps2_code_fifo.sv
// Bench for ps2_code_fifo: two DEPTH=4 instances (drop and overwrite policy) driven in lockstep
// and compared every cycle against a queue-based reference model.
module tb_ps2_code_fifo;

  localparam int DEP = 4;
  localparam int W   = 15;

  logic clk;
  logic reset;

  ps2_code_fifo_if #(.WIDTH(8), .DEPTH(DEP)) bus0 ();
  ps2_code_fifo_if #(.WIDTH(8), .DEPTH(DEP)) bus1 ();

  ps2_code_fifo #(.WIDTH(8), .DEPTH(DEP), .OVERWRITE(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  ps2_code_fifo #(.WIDTH(8), .DEPTH(DEP), .OVERWRITE(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [2*W-1:0] exp_q[$];
  logic [7:0]     mq0[$];
  logic [7:0]     mq1[$];
  bit             m_ovf[2];
  bit             m_udf[2];
  int             total = 0;
  int             bad   = 0;

  // Reference model: the buffer is a plain queue of codes; the policy index picks drop (0)
  // or overwrite (1) when a lone push meets a full buffer.
  task automatic model_step(input int p, input logic rst_n, input logic cl, input logic ps,
                            input logic pp, input logic [7:0] d, output logic [W-1:0] e);
    logic [7:0] q[$];
    bit ov;
    bit un;
    logic [7:0] head;
    if (p == 0) q = mq0; else q = mq1;
    ov = m_ovf[p];
    un = m_udf[p];
    if (!rst_n || cl) begin
      q.delete();
      ov = 0;
      un = 0;
    end else begin
      if (pp && q.size() == 0) un = 1;
      if (ps && !pp && q.size() == DEP) begin
        ov = 1;
        if (p == 1) begin
          void'(q.pop_front());
          q.push_back(d);
        end
      end else begin
        if (pp && q.size() > 0) void'(q.pop_front());
        if (ps) q.push_back(d);
      end
    end
    if (p == 0) mq0 = q; else mq1 = q;
    m_ovf[p] = ov;
    m_udf[p] = un;
    head = (q.size() > 0) ? q[0] : 8'h00;
    e = {head, 3'(q.size()), q.size() == 0, q.size() == DEP, ov, un};
  endtask

  // driver: one call = one clock edge of stimulus
  task automatic cycle(input logic rst_n, input logic cl, input logic ps, input logic pp,
                       input logic [7:0] d);
    logic [W-1:0] e0;
    logic [W-1:0] e1;
    @(negedge clk);
    reset      = rst_n;
    bus0.clear = cl;  bus1.clear = cl;
    bus0.push  = ps;  bus1.push  = ps;
    bus0.pop   = pp;  bus1.pop   = pp;
    bus0.din   = d;   bus1.din   = d;
    model_step(0, rst_n, cl, ps, pp, d, e0);
    model_step(1, rst_n, cl, ps, pp, d, e1);
    exp_q.push_back({e1, e0});
  endtask

  task automatic do_push(input logic [7:0] d); cycle(1'b1, 1'b0, 1'b1, 1'b0, d); endtask
  task automatic do_pop();                     cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'h00); endtask
  task automatic do_idle();                    cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00); endtask
  task automatic do_clear();                   cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00); endtask

  task automatic check(input int p, input logic [W-1:0] exp, input logic [W-1:0] act);
    total++;
    if (exp !== act) begin
      bad++;
      $display("FAIL inst%0d t=%0t: got dout=%h cnt=%0d e=%b f=%b ov=%b un=%b, want dout=%h cnt=%0d e=%b f=%b ov=%b un=%b",
               p, $time, act[14:7], act[6:4], act[3], act[2], act[1], act[0],
               exp[14:7], exp[6:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  // monitor: after each edge, compare both instances to the oldest expectation
  always begin
    logic [2*W-1:0] e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(0, e[W-1:0],
            {bus0.dout, bus0.count, bus0.empty, bus0.full, bus0.overflow, bus0.underflow});
      check(1, e[2*W-1:W],
            {bus1.dout, bus1.count, bus1.empty, bus1.full, bus1.overflow, bus1.underflow});
    end
  end

  initial begin
    reset = 1'b0;
    bus0.clear = 1'b0; bus0.push = 1'b0; bus0.pop = 1'b0; bus0.din = 8'h00;
    bus1.clear = 1'b0; bus1.push = 1'b0; bus1.pop = 1'b0; bus1.din = 8'h00;

    // reset, idle, single code latency
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    repeat (2) do_idle();
    do_push(8'h1C);
    do_pop();
    do_idle();

    // fill to full and drain in order, then empty reads 0
    do_push(8'h1C); do_push(8'hF0); do_push(8'h1C); do_push(8'h32);
    repeat (4) do_pop();
    do_idle();

    // full-policy split: 01..04 then 05; drain, one extra pop for underflow
    for (int i = 1; i <= 5; i++) do_push(8'(i));
    do_idle();
    repeat (5) do_pop();
    do_clear();

    // full with simultaneous push/pop, then empty with simultaneous push/pop
    for (int i = 0; i < DEP; i++) do_push(8'h11 + 8'(i));
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 8'hAA);
    repeat (4) do_pop();
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 8'h55);
    do_clear();

    // pointer wrap: 3*DEPTH push/pop pairs with incrementing data
    do_push(8'h80);
    for (int i = 1; i <= 3 * DEP; i++) cycle(1'b1, 1'b0, 1'b1, 1'b1, 8'h80 + 8'(i));
    do_pop();
    do_idle();

    // flush with push 77 pending, via clear and then via reset
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < DEP + 1; i++) do_push(8'h40 + 8'(i));
      do_pop();
      if (k == 0) cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'h77);
      else        cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h77);
      do_idle();
    end

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic rn, cl, ps, pp;
      rn = ($urandom_range(0, 99) != 0);
      cl = ($urandom_range(0, 59) == 0);
      ps = ($urandom_range(0, 99) < 55);
      pp = ($urandom_range(0, 99) < 45);
      cycle(rn, cl, ps, pp, 8'($urandom_range(0, 255)));
    end

    @(posedge clk);
    #3;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
